// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared FSM encoding, forward-select codes and the forwarding rule.
package pipeline_ctrl_pkg;
   typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] mem_rd,
                                           input logic mem_we, input logic [4:0] wb_rd, input logic wb_we);
      return (mem_we && mem_rd != 5'd0 && mem_rd == rs) ? FWD_MEM :
             (wb_we && wb_rd != 5'd0 && wb_rd == rs) ? FWD_WB : FWD_REG;
   endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, cleared by asynchronous reset.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= '0;
      else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: load-use/branch hazard control, operand forwarding and
// data-memory wait handling with timeout for a 5-stage pipeline.
module pipeline_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 255,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       idex_rs1,
   input  logic [4:0]       idex_rs2,
   input  logic [4:0]       idex_rd,
   input  logic             idex_memRead,
   input  logic [4:0]       exmem_rd,
   input  logic             exmem_regWrite,
   input  logic [4:0]       memwb_rd,
   input  logic             memwb_regWrite,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_bubble,
   output logic [1:0]       forwardA,
   output logic [1:0]       forwardB,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count,
   output logic             mem_error
);
   localparam int WW = $clog2(MAX_WAIT + 1);
   state_t        st, st_nxt;
   logic [WW-1:0] wcnt, wcnt_nxt;
   logic          load_use, br_fire;
   assign load_use  = idex_memRead && idex_rd != 5'd0 && (idex_rd == id_rs1 || idex_rd == id_rs2);
   assign mem_error = st == ERROR;
   assign forwardA  = rst_n ? fwd_sel(idex_rs1, exmem_rd, exmem_regWrite, memwb_rd, memwb_regWrite) : FWD_REG;
   assign forwardB  = rst_n ? fwd_sel(idex_rs2, exmem_rd, exmem_regWrite, memwb_rd, memwb_regWrite) : FWD_REG;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st   <= RUN;
         wcnt <= '0;
      end else begin
         st   <= st_nxt;
         wcnt <= wcnt_nxt;
      end
   // The cycle that first sees a stalled access already freezes the pipe.
   always_comb begin
      st_nxt       = st;
      wcnt_nxt     = wcnt;
      br_fire      = 1'b0;
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;
      if (!rst_n) begin
         {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
         {ifid_flush, idex_flush, memwb_bubble} = 3'b111;
      end else if (st == ERROR || (dmem_req && !dmem_ready && st == RUN) || (st == MEM_WAIT && !dmem_ready)) begin
         {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
         memwb_bubble = 1'b1;
         if (st == RUN) begin
            st_nxt   = MEM_WAIT;
            wcnt_nxt = WW'(1);
         end else if (st == MEM_WAIT) begin
            st_nxt   = (int'(wcnt) + 1 >= MAX_WAIT) ? ERROR : MEM_WAIT;
            wcnt_nxt = wcnt + 1'b1;
         end
      end else if (st == MEM_WAIT) begin
         st_nxt   = RUN;
         wcnt_nxt = '0;
      end else if (branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         br_fire    = 1'b1;
      end else if (load_use) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end
   sat_counter #(.WIDTH(CNT_W)) u_stall (.clk(clk), .rst_n(rst_n), .inc(!pc_en), .count(stall_cycles));
   sat_counter #(.WIDTH(CNT_W)) u_flush (.clk(clk), .rst_n(rst_n), .inc(br_fire), .count(flush_count));
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed scenario tests with hand-computed expectations.
module tb_pipeline_controller;
   logic       clk, rst_n;
   logic [4:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
   logic       idex_memRead, exmem_regWrite, memwb_regWrite, branch_taken, dmem_req, dmem_ready;
   logic       pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble, mem_error;
   logic [1:0] forwardA, forwardB;
   logic [3:0] stall_cycles, flush_count;
   logic [6:0] ctl;
   int         checks = 0;
   int         errors = 0;
   localparam logic [6:0] C_RUN = 7'b1111000, C_FRZ = 7'b0000001, C_LU = 7'b0011010;
   localparam logic [6:0] C_BR = 7'b1111110, C_RST = 7'b0000111;
   assign ctl = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble};
   pipeline_controller #(.MAX_WAIT(4), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .idex_rs1(idex_rs1),
      .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_memRead(idex_memRead), .exmem_rd(exmem_rd),
      .exmem_regWrite(exmem_regWrite), .memwb_rd(memwb_rd), .memwb_regWrite(memwb_regWrite),
      .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(pc_en),
      .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .memwb_bubble(memwb_bubble), .forwardA(forwardA), .forwardB(forwardB),
      .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_error(mem_error)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic clear_inputs();
      {id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd} = '0;
      {idex_memRead, exmem_regWrite, memwb_regWrite, branch_taken, dmem_req, dmem_ready} = '0;
   endtask
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      #2 rst_n = 1'b0;
      clear_inputs();
      next_cycle();
      rst_n = 1'b1;
   endtask
   task automatic test_reset();
      #2 rst_n = 1'b0;
      clear_inputs();
      exmem_regWrite = 1'b1; exmem_rd = 5'd3; idex_rs1 = 5'd3; idex_rs2 = 5'd3;
      #1;
      checks++; if (ctl !== C_RST) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, C_RST); end
      checks++; if ({forwardA, forwardB} !== 4'b0000) begin errors++; $display("FAIL reset_fwd got %b exp 0000", {forwardA, forwardB}); end
      checks++; if ({stall_cycles, flush_count, mem_error} !== 9'd0) begin errors++; $display("FAIL reset_cnt got %h %h %b exp 0 0 0", stall_cycles, flush_count, mem_error); end
      next_cycle();
      rst_n = 1'b1;
      clear_inputs();
      #3;
      checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL post_reset_run got %b exp %b", ctl, C_RUN); end
   endtask
   task automatic test_load_use();
      do_reset();
      idex_memRead = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5;
      #3;
      checks++; if (ctl !== C_LU) begin errors++; $display("FAIL load_use_ctl got %b exp %b", ctl, C_LU); end
      next_cycle();
      clear_inputs();
      #3;
      checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL load_use_release got %b exp %b", ctl, C_RUN); end
      checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL load_use_stalls got %0d exp 1", stall_cycles); end
      idex_memRead = 1'b1; idex_rd = 5'd9; id_rs2 = 5'd9; id_rs1 = 5'd2;
      #1;
      checks++; if (ctl !== C_LU) begin errors++; $display("FAIL load_use_rs2 got %b exp %b", ctl, C_LU); end
   endtask
   task automatic test_load_x0();
      do_reset();
      idex_memRead = 1'b1; idex_rd = 5'd0; id_rs1 = 5'd0;
      #3;
      checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL load_x0_ctl got %b exp %b", ctl, C_RUN); end
      next_cycle();
      clear_inputs();
      #3;
      checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL load_x0_stalls got %0d exp 0", stall_cycles); end
   endtask
   task automatic test_mem_wait();
      do_reset();
      dmem_req = 1'b1;
      #3;
      checks++; if (ctl !== C_FRZ) begin errors++; $display("FAIL mw_first got %b exp %b", ctl, C_FRZ); end
      next_cycle();
      branch_taken = 1'b1;
      #3;
      checks++; if (ctl !== C_FRZ) begin errors++; $display("FAIL mw_branch_ignored got %b exp %b", ctl, C_FRZ); end
      next_cycle();
      branch_taken = 1'b0;
      #3;
      checks++; if (ctl !== C_FRZ) begin errors++; $display("FAIL mw_third got %b exp %b", ctl, C_FRZ); end
      next_cycle();
      dmem_ready = 1'b1;
      #3;
      checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL mw_ready got %b exp %b", ctl, C_RUN); end
      next_cycle();
      clear_inputs();
      branch_taken = 1'b1;
      #3;
      checks++; if (ctl !== C_BR) begin errors++; $display("FAIL mw_after_branch got %b exp %b", ctl, C_BR); end
      checks++; if ({stall_cycles, flush_count} !== {4'd3, 4'd0}) begin errors++; $display("FAIL mw_counts got %0d %0d exp 3 0", stall_cycles, flush_count); end
      next_cycle();
      clear_inputs();
      #3;
      checks++; if (flush_count !== 4'd1) begin errors++; $display("FAIL mw_flush_after got %0d exp 1", flush_count); end
   endtask
   task automatic test_branch();
      do_reset();
      branch_taken = 1'b1; idex_memRead = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5;
      #3;
      checks++; if (ctl !== C_BR) begin errors++; $display("FAIL branch_ctl got %b exp %b", ctl, C_BR); end
      next_cycle();
      clear_inputs();
      #3;
      checks++; if ({flush_count, stall_cycles} !== {4'd1, 4'd0}) begin errors++; $display("FAIL branch_counts got %0d %0d exp 1 0", flush_count, stall_cycles); end
      branch_taken = 1'b1;
      repeat (18) next_cycle();
      branch_taken = 1'b0;
      #3;
      checks++; if (flush_count !== 4'd15) begin errors++; $display("FAIL flush_saturate got %0d exp 15", flush_count); end
   endtask
   task automatic test_forward();
      do_reset();
      exmem_rd = 5'd7; memwb_rd = 5'd7; idex_rs1 = 5'd7; exmem_regWrite = 1'b1; memwb_regWrite = 1'b1;
      #1;
      checks++; if (forwardA !== 2'b10) begin errors++; $display("FAIL fwdA_mem got %b exp 10", forwardA); end
      exmem_regWrite = 1'b0;
      #1;
      checks++; if (forwardA !== 2'b01) begin errors++; $display("FAIL fwdA_wb got %b exp 01", forwardA); end
      memwb_regWrite = 1'b0;
      #1;
      checks++; if (forwardA !== 2'b00) begin errors++; $display("FAIL fwdA_reg got %b exp 00", forwardA); end
      exmem_rd = 5'd0; idex_rs1 = 5'd0; idex_rs2 = 5'd0; exmem_regWrite = 1'b1;
      #1;
      checks++; if ({forwardA, forwardB} !== 4'b0000) begin errors++; $display("FAIL fwd_x0 got %b exp 0000", {forwardA, forwardB}); end
      exmem_rd = 5'd12; idex_rs2 = 5'd12; idex_rs1 = 5'd4; memwb_rd = 5'd4; memwb_regWrite = 1'b1;
      #1;
      checks++; if ({forwardA, forwardB} !== 4'b0110) begin errors++; $display("FAIL fwd_split got %b exp 0110", {forwardA, forwardB}); end
   endtask
   task automatic test_error();
      do_reset();
      dmem_req = 1'b1;
      repeat (3) begin
         #3;
         checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL err_early got %b exp 0", mem_error); end
         next_cycle();
      end
      #3;
      checks++; if ({mem_error, ctl} !== {1'b0, C_FRZ}) begin errors++; $display("FAIL err_fourth got %b exp %b", {mem_error, ctl}, {1'b0, C_FRZ}); end
      next_cycle();
      dmem_ready = 1'b1; idex_rs2 = 5'd4; memwb_rd = 5'd4; memwb_regWrite = 1'b1;
      #3;
      checks++; if ({mem_error, ctl} !== {1'b1, C_FRZ}) begin errors++; $display("FAIL err_enter got %b exp %b", {mem_error, ctl}, {1'b1, C_FRZ}); end
      checks++; if (forwardB !== 2'b01) begin errors++; $display("FAIL err_fwdB got %b exp 01", forwardB); end
      repeat (20) next_cycle();
      #3;
      checks++; if ({mem_error, ctl} !== {1'b1, C_FRZ}) begin errors++; $display("FAIL err_sticky got %b exp %b", {mem_error, ctl}, {1'b1, C_FRZ}); end
      checks++; if (stall_cycles !== 4'd15) begin errors++; $display("FAIL stall_saturate got %0d exp 15", stall_cycles); end
      rst_n = 1'b0;
      #1;
      checks++; if ({mem_error, stall_cycles, ctl} !== {1'b0, 4'd0, C_RST}) begin errors++; $display("FAIL err_async_reset got %b exp %b", {mem_error, stall_cycles, ctl}, {1'b0, 4'd0, C_RST}); end
      clear_inputs();
      #1 rst_n = 1'b1;
      #1;
      checks++; if ({mem_error, ctl} !== {1'b0, C_RUN}) begin errors++; $display("FAIL err_release got %b exp %b", {mem_error, ctl}, {1'b0, C_RUN}); end
      next_cycle();
      #3;
      checks++; if ({mem_error, ctl, stall_cycles} !== {1'b0, C_RUN, 4'd0}) begin errors++; $display("FAIL err_first_edge got %b exp %b", {mem_error, ctl, stall_cycles}, {1'b0, C_RUN, 4'd0}); end
   endtask
   initial begin
      rst_n = 1'b0;
      clear_inputs();
      next_cycle();
      test_reset();
      test_load_use();
      test_load_x0();
      test_mem_wait();
      test_branch();
      test_forward();
      test_error();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
